dma_priority_arbiter: RTL

//  Upstream stage of the DMA timing-control FSM. Synchronises DREQ pins, merges mask and software-request registers,
//  and resolves fixed/rotating priority. Locks one channel per service and presents it as one-hot VALID_DREQ to the FSM.

---
 rtl/dma_priority_arbiter_if.sv | 40 ++++
 rtl/dma_priority_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dma_priority_arbiter_if
//  Purpose  : Request/grant/acknowledge bundle between the DMA register block,
//             the priority arbiter and the DMA timing FSM.
//  Revision : 1.0  initial release
// ============================================================================
interface dma_priority_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0] DREQ;
    logic              dreqSenseHigh;
    logic              dackSenseHigh;
    logic              rotatingPrio;
    logic              ctrlDisable;
    logic [NUM_CH-1:0] maskReg;
    logic [NUM_CH-1:0] requestReg;
    logic              validDACK;
    logic              serviceDone;
    logic [NUM_CH-1:0] VALID_DREQ;
    logic [PTR_W-1:0]  grantCh;
    logic              grantValid;
    logic [NUM_CH-1:0] DACK;
    logic [NUM_CH-1:0] swReqClr;
    logic [NUM_CH-1:0] reqStatus;

    modport master (
        output DREQ, dreqSenseHigh, dackSenseHigh, rotatingPrio, ctrlDisable,
               maskReg, requestReg, validDACK, serviceDone,
        input  VALID_DREQ, grantCh, grantValid, DACK, swReqClr, reqStatus
    );

    modport slave (
        input  DREQ, dreqSenseHigh, dackSenseHigh, rotatingPrio, ctrlDisable,
               maskReg, requestReg, validDACK, serviceDone,
        output VALID_DREQ, grantCh, grantValid, DACK, swReqClr, reqStatus
    );
endinterface
`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dma_priority_arbiter
//  Purpose  : DREQ synchronisation, mask/software-request merge, fixed or
//             rotating priority, per-service channel lock and DACK drive.
//  Revision : 1.0  initial release
// ============================================================================
module dma_priority_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic              CLK,
    input  wire logic              RESET_N,
    dma_priority_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [PTR_W-1:0]  r_grant;
    logic [PTR_W-1:0]  w_grant_nxt;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic              r_sw_locked;
    logic              w_sw_locked_nxt;
    logic [NUM_CH-1:0] r_sync [SYNC_STAGES];

    logic [NUM_CH-1:0] w_dreq_sync;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_onehot;
    logic [PTR_W-1:0]  w_winner;
    logic              w_found;
    logic              w_locked;

    // DREQ pins are asynchronous; only the last stage is used by logic
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= bus.DREQ;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_dreq_sync = r_sync[SYNC_STAGES-1] ^ {NUM_CH{bus.dreqSenseHigh}};
    assign w_pending   = (w_dreq_sync & ~bus.maskReg) | bus.requestReg;

    // Search order starts at the pointer in rotating mode, at channel 0 otherwise
    always_comb begin
        int                idx;
        logic [PTR_W-1:0]  idx_p;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = bus.rotatingPrio ? (int'(r_ptr) + k) : k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_p = PTR_W'(idx);
            if (!w_found && w_pending[idx_p]) begin
                w_found  = 1'b1;
                w_winner = idx_p;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_sw_locked <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_ptr       <= w_ptr_nxt;
            r_sw_locked <= w_sw_locked_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_ptr_nxt       = r_ptr;
        w_sw_locked_nxt = r_sw_locked;
        case (r_state)
            ARB_IDLE: begin
                if (!bus.ctrlDisable && w_found) begin
                    w_grant_nxt     = w_winner;
                    w_sw_locked_nxt = bus.requestReg[w_winner];
                    w_state_nxt     = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                // Lock is held until the timing FSM reports completion
                if (bus.serviceDone) begin
                    w_state_nxt = ARB_IDLE;
                    if (bus.rotatingPrio) begin
                        w_ptr_nxt = (r_grant == PTR_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign w_locked       = (r_state == ARB_LOCK);
    assign w_onehot       = {{(NUM_CH-1){1'b0}}, 1'b1} << r_grant;
    assign bus.VALID_DREQ = w_locked ? w_onehot : '0;
    assign bus.grantValid = w_locked;
    assign bus.grantCh    = r_grant;
    assign bus.reqStatus  = w_dreq_sync;
    assign bus.swReqClr   = (w_locked && bus.serviceDone && r_sw_locked) ? w_onehot : '0;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_dack
            assign bus.DACK[i] = (w_locked && bus.validDACK && (r_grant == PTR_W'(i)))
                                 ? bus.dackSenseHigh : ~bus.dackSenseHigh;
        end
    endgenerate
endmodule
`default_nettype wire
